// File: rtl/bus_slot_arbiter.sv
// Time-division arbiter for the shared PET bus: fixed 16-clock frames of video, MCU and 6502 slots.
// Latency: all outputs registered, computed one clock ahead from the frame counter; no backpressure, the requester holds mcu_req_i until mcu_done_o.
module bus_slot_arbiter #(
    parameter int VIDEO_FETCHES = 2
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       mcu_req_i,
    input  logic       cpu_halt_i,
    output logic       cpu_be_o,
    output logic       cpu_clk_o,
    output logic       bus_oe_o,
    output logic       video_grant_o,
    output logic       video_idx_o,
    output logic       mcu_grant_o,
    output logic       strobe_o,
    output logic       mcu_done_o,
    output logic [3:0] cycle_o
);

    logic [3:0] c_q;
    logic [3:0] c_n;
    logic       halt_q;
    logic       slot_q;

    logic       halt_eff;
    logic       samp;
    logic       mid;
    logic       mcu_g_n;
    logic       mcu_last_n;
    logic       vid0_n;
    logic       vid1_n;
    logic       vid_g_n;
    logic       vid_st_n;
    logic       be_n;
    logic       clk_n;

    always_comb begin
        c_n      = c_q + 4'd1;
        // halt is captured at the end of c=7 and must already shape the c=8 outputs
        halt_eff = (c_q == 4'd7) ? cpu_halt_i : halt_q;

        // samp: last clock before an MCU slot; mid: first clock of the slot
        samp = (c_q == 4'd4) || (halt_q && ((c_q == 4'd8) || (c_q == 4'd12)));
        mid  = (c_q == 4'd5) || (halt_q && ((c_q == 4'd9) || (c_q == 4'd13)));

        mcu_g_n    = 1'b0;
        if (samp) begin
            mcu_g_n = mcu_req_i;
        end else if (mid) begin
            mcu_g_n = slot_q;
        end
        mcu_last_n = mid && slot_q;

        vid0_n   = (VIDEO_FETCHES > 0) && ((c_n == 4'd1) || (c_n == 4'd2));
        vid1_n   = (VIDEO_FETCHES > 1) && ((c_n == 4'd3) || (c_n == 4'd4));
        vid_g_n  = vid0_n || vid1_n;
        vid_st_n = (vid0_n && (c_n == 4'd2)) || (vid1_n && (c_n == 4'd4));

        // c=7 and c=0 stay dead so ownership never flips without an idle clock
        be_n  = c_n[3] && !halt_eff;
        clk_n = c_n[3] && c_n[2] && !halt_eff;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            c_q           <= 4'd0;
            halt_q        <= 1'b0;
            slot_q        <= 1'b0;
            cpu_be_o      <= 1'b0;
            cpu_clk_o     <= 1'b0;
            bus_oe_o      <= 1'b0;
            video_grant_o <= 1'b0;
            video_idx_o   <= 1'b0;
            mcu_grant_o   <= 1'b0;
            strobe_o      <= 1'b0;
            mcu_done_o    <= 1'b0;
        end else begin
            c_q <= c_n;
            if (c_q == 4'd7) begin
                halt_q <= cpu_halt_i;
            end
            if (samp) begin
                slot_q <= mcu_req_i;
            end
            cpu_be_o      <= be_n;
            cpu_clk_o     <= clk_n;
            bus_oe_o      <= vid_g_n || mcu_g_n;
            video_grant_o <= vid_g_n;
            video_idx_o   <= vid1_n;
            mcu_grant_o   <= mcu_g_n;
            strobe_o      <= vid_st_n || mcu_last_n;
            mcu_done_o    <= mcu_last_n;
        end
    end

    assign cycle_o = c_q;

endmodule

// File: tb/tb_bus_slot_arbiter.sv
// Bench for bus_slot_arbiter: frame table, multi-cycle handshake/halt/reset sequences,
// and a random run against a frame-level model for VIDEO_FETCHES=2 and 0.
`timescale 1ns/1ps
module tb_bus_slot_arbiter;

    logic clk = 1'b0;
    logic reset;
    logic req;
    logic halt;

    always #31 clk = ~clk;

    logic       be2, clk2, oe2, vg2, vi2, mg2, st2, dn2;
    logic [3:0] cyc2;
    logic       be0, clk0, oe0, vg0, vi0, mg0, st0, dn0;
    logic [3:0] cyc0;
    logic [7:0] o2, o0;

    assign o2 = {be2, clk2, oe2, vg2, vi2, mg2, st2, dn2};
    assign o0 = {be0, clk0, oe0, vg0, vi0, mg0, st0, dn0};

    bus_slot_arbiter #(.VIDEO_FETCHES(2)) dut (
        .clk_i(clk), .reset_i(reset), .mcu_req_i(req), .cpu_halt_i(halt),
        .cpu_be_o(be2), .cpu_clk_o(clk2), .bus_oe_o(oe2), .video_grant_o(vg2),
        .video_idx_o(vi2), .mcu_grant_o(mg2), .strobe_o(st2), .mcu_done_o(dn2),
        .cycle_o(cyc2)
    );

    bus_slot_arbiter #(.VIDEO_FETCHES(0)) dut0 (
        .clk_i(clk), .reset_i(reset), .mcu_req_i(req), .cpu_halt_i(halt),
        .cpu_be_o(be0), .cpu_clk_o(clk0), .bus_oe_o(oe0), .video_grant_o(vg0),
        .video_idx_o(vi0), .mcu_grant_o(mg0), .strobe_o(st0), .mcu_done_o(dn0),
        .cycle_o(cyc0)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic r, input logic h);
        req  = r;
        halt = h;
        @(negedge clk);
    endtask

    // output vector order: {be, clk, oe, video_grant, video_idx, mcu_grant, strobe, done}
    typedef struct {
        logic       r;
        logic [7:0] e;
    } row_t;
    row_t tbl [32];

    logic [7:0] f_req [16] = '{8'h00, 8'h30, 8'h32, 8'h38, 8'h3A, 8'h24, 8'h27, 8'h00,
                               8'h80, 8'h80, 8'h80, 8'h80, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
    logic [7:0] f_idle [16] = '{8'h00, 8'h30, 8'h32, 8'h38, 8'h3A, 8'h00, 8'h00, 8'h00,
                                8'h80, 8'h80, 8'h80, 8'h80, 8'hC0, 8'hC0, 8'hC0, 8'hC0};

    // inputs seen during each cycle of the current random frame
    logic rq [16];
    logic hl [16];

    function automatic logic [7:0] exp_vec(input int vf, input int c);
        logic hf, mcu, mlast, vg, vi, vst, be, ck;
        int   vk;
        hf    = (c >= 8) && hl[7];
        mcu   = ((c == 5 || c == 6) && rq[4]) ||
                (hf && (((c == 9 || c == 10) && rq[8]) || ((c == 13 || c == 14) && rq[12])));
        mlast = mcu && (c == 6 || c == 10 || c == 14);
        vk    = (c == 1 || c == 2) ? 0 : ((c == 3 || c == 4) ? 1 : -1);
        vg    = (vk >= 0) && (vk < vf);
        vi    = vg && (vk == 1);
        vst   = vg && (c == 2 || c == 4);
        be    = (c >= 8) && !hf;
        ck    = (c >= 12) && !hf;
        return {be, ck, vg || mcu, vg, vi, mcu, vst || mlast, mlast};
    endfunction

    initial begin
        int   ndone;
        logic rcur, h, pbe2, poe2, pbe0, poe0, first;

        for (int i = 0; i < 32; i++) begin
            tbl[i].r = (i >= 2 && i <= 6);
            tbl[i].e = (i < 16) ? f_req[i] : f_idle[i - 16];
        end

        reset = 1'b1;
        req   = 1'b0;
        halt  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_out", o2, 8'h00);
            chk("reset_cyc", cyc2, 4'd0);
        end
        reset = 1'b0;

        // frame 1: request raised at c=2, dropped after done; frame 2 idle
        for (int i = 0; i < 32; i++) begin
            chk("tbl_out", o2, tbl[i].e);
            chk("tbl_cyc", cyc2, i % 16);
            cyc(tbl[i].r, 1'b0);
        end

        // request rising at c=5 misses this frame's sample, served next frame
        for (int c = 0; c < 16; c++) begin
            if (c == 5 || c == 6) chk("late_nogrant", mg2, 0);
            cyc(c >= 5, 1'b0);
        end
        for (int c = 0; c < 16; c++) begin
            if (c == 5 || c == 6) chk("late_grant", mg2, 1);
            if (c == 6) chk("late_done", dn2, 1);
            cyc(c <= 6, 1'b0);
        end

        // halt at c=7 with request held: three MCU slots, CPU off the bus
        ndone = 0;
        for (int c = 0; c < 16; c++) begin
            chk("halt_grant", mg2, (c == 5 || c == 6 || c == 9 || c == 10 || c == 13 || c == 14));
            if (c >= 8) chk("halt_cpu_off", {be2, clk2}, 2'b00);
            ndone += int'(dn2);
            cyc(c != 15, c == 7);
        end
        chk("halt_done_count", ndone, 3);
        chk("halt_cpu_back", cyc2, 0);

        // reset during an MCU grant
        for (int c = 0; c < 5; c++) cyc(1'b1, 1'b0);
        chk("rst_mid_grant", mg2, 1);
        reset = 1'b1;
        cyc(1'b0, 1'b0);
        reset = 1'b0;
        chk("rst_mid_out", o2, 8'h00);
        for (int k = 0; k < 16; k++) begin
            chk("rst_mid_cyc", cyc2, k);
            chk("rst_mid_nodone", dn2, 0);
            cyc(1'b0, 1'b0);
        end

        // random frames against the frame-level model, both configurations
        rcur  = 1'b0;
        first = 1'b1;
        pbe2 = 1'b0; poe2 = 1'b0; pbe0 = 1'b0; poe0 = 1'b0;
        for (int f = 0; f < 1000; f++) begin
            for (int c = 0; c < 16; c++) begin
                chk("rnd_vf2", o2, exp_vec(2, c));
                chk("rnd_vf0", o0, exp_vec(0, c));
                if (c == 0) chk("rnd_cyc", cyc2, 0);
                chk("rnd_vf0_novideo", vg0, 0);
                chk("excl_vf2", be2 && oe2, 0);
                chk("excl_vf0", be0 && oe0, 0);
                chk("grant_excl", vg2 && mg2, 0);
                if (!first) begin
                    chk("gap_vf2", (pbe2 && oe2) || (poe2 && be2), 0);
                    chk("gap_vf0", (pbe0 && oe0) || (poe0 && be0), 0);
                end
                first = 1'b0;
                pbe2 = be2; poe2 = oe2; pbe0 = be0; poe0 = oe0;
                if ($urandom_range(3) == 0) rcur = ~rcur;
                h     = ($urandom_range(2) == 0);
                rq[c] = rcur;
                hl[c] = h;
                cyc(rcur, h);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
